// File: rtl/shift_pkg.sv
// Shared types for the operand-2 shift sequencer: shift encodings, FSM states
// and the datapath word width.
package shift_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational shifter that moves a word by 1..STEP bits and reports the
// last bit shifted out, so the sequencer can iterate it over several cycles.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = 4,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [WORD-1:0] value,
  input  shift_t          shift_type,
  input  logic [KW-1:0]   k,
  output logic [WORD-1:0] shifted,
  output logic            carry
);

  logic [5:0] k6;
  logic [4:0] lsl_idx;
  logic [4:0] rsh_idx;

  assign k6      = 6'(k);
  assign lsl_idx = 5'(6'd32 - k6);
  assign rsh_idx = 5'(k6 - 6'd1);

  // Right-going shifts lose bit k-1 last; LSL loses bit 32-k last.
  always_comb begin
    shifted = value;
    carry   = value[rsh_idx];
    case (shift_type)
      LSL: begin
        shifted = value << k6;
        carry   = value[lsl_idx];
      end
      LSR:     shifted = value >> k6;
      ASR:     shifted = $unsigned($signed(value) >>> k6);
      ROR:     shifted = (value >> k6) | (value << (6'd32 - k6));
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/operand2_shift_sequencer.sv
// Operand-2 controller: resolves immediate/register shift requests, handles the
// out-of-range amounts in one cycle and iterates a STEP-bit shifter otherwise.
module operand2_shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             imm_mode,
  input  logic [7:0]       imm8,
  input  logic [3:0]       rot4,
  input  logic [WORD-1:0]  operand,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       shift_amt,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  result,
  output logic             carry_out,
  output logic             busy,
  output seq_state_t       state_dbg
);

  localparam int         KW    = $clog2(STEP + 1);
  localparam logic [4:0] STEP5 = 5'(STEP);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready is only high in IDLE, and out_valid holds its payload
  // steady in DONE until out_ready completes the transfer.

  seq_state_t      state_q;
  logic [WORD-1:0] work_q;
  shift_t          type_q;
  logic [4:0]      rem_q;
  logic [WORD-1:0] result_q;
  logic            carry_q;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            busy_q;

  logic [WORD-1:0] cap_value;
  shift_t          cap_type;
  logic [7:0]      cap_amt;

  always_comb begin
    if (imm_mode) begin
      cap_value = {24'b0, imm8};
      cap_type  = ROR;
      cap_amt   = {3'b0, rot4, 1'b0};
    end else begin
      cap_value = operand;
      cap_type  = shift_t'(shift_type);
      cap_amt   = shift_amt;
    end
  end

  logic            spec_hit;
  logic [WORD-1:0] spec_result;
  logic            spec_carry;
  logic [4:0]      norm_amt;

  // Zero and >=32 amounts finish at capture; ROR by a non-multiple of 32
  // folds to its low five bits and takes the iterative path.
  always_comb begin
    spec_hit    = 1'b0;
    spec_result = cap_value;
    spec_carry  = carry_in;
    norm_amt    = cap_amt[4:0];
    if (cap_amt == 8'd0) begin
      spec_hit = 1'b1;
    end else if (cap_amt >= 8'd32) begin
      case (cap_type)
        LSL: begin
          spec_hit    = 1'b1;
          spec_result = '0;
          spec_carry  = (cap_amt == 8'd32) ? cap_value[0] : 1'b0;
        end
        LSR: begin
          spec_hit    = 1'b1;
          spec_result = '0;
          spec_carry  = (cap_amt == 8'd32) ? cap_value[31] : 1'b0;
        end
        ASR: begin
          spec_hit    = 1'b1;
          spec_result = {WORD{cap_value[31]}};
          spec_carry  = cap_value[31];
        end
        ROR: begin
          if (cap_amt[4:0] == 5'd0) begin
            spec_hit    = 1'b1;
            spec_result = cap_value;
            spec_carry  = cap_value[31];
          end
        end
        default: spec_hit = 1'b0;
      endcase
    end
  end

  logic [4:0]      k5;
  logic [4:0]      rem_next;
  logic [WORD-1:0] step_value;
  logic            step_carry;

  assign k5       = (rem_q < STEP5) ? rem_q : STEP5;
  assign rem_next = rem_q - k5;

  shift_step #(.STEP(STEP)) u_step (
    .value      (work_q),
    .shift_type (type_q),
    .k          (KW'(k5)),
    .shifted    (step_value),
    .carry      (step_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      type_q      <= LSL;
      rem_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            work_q     <= cap_value;
            type_q     <= cap_type;
            if (spec_hit) begin
              result_q    <= spec_result;
              carry_q     <= spec_carry;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q   <= norm_amt;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= step_value;
          rem_q  <= rem_next;
          // Only the final step's carry matters, so it is latched on exit.
          if (rem_next == 5'd0) begin
            result_q    <= step_value;
            carry_q     <= step_carry;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_operand2_shift_sequencer.sv
// Directed bench for operand2_shift_sequencer: a STEP=4 instance checked via a
// scoreboard queue and monitor, plus a STEP=1 instance for the latency case.
module tb_operand2_shift_sequencer;
  import shift_pkg::*;

  localparam int W = 41;  // {latency[7:0], carry, result[31:0]}

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_valid1;
  logic        imm_mode;
  logic [7:0]  imm8;
  logic [3:0]  rot4;
  logic [31:0] operand;
  logic [1:0]  shift_type;
  logic [7:0]  shift_amt;
  logic        carry_in;
  logic        out_ready, out_ready1;

  logic        in_ready, out_valid, carry_out, busy;
  logic [31:0] result;
  seq_state_t  state_dbg;
  logic        in_ready1, out_valid1, carry_out1, busy1;
  logic [31:0] result1;
  seq_state_t  state_dbg1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [W-1:0] exp1_q[$];
  int           acc1_q[$];

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operand2_shift_sequencer #(.STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_mode(imm_mode), .imm8(imm8), .rot4(rot4), .operand(operand),
    .shift_type(shift_type), .shift_amt(shift_amt), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .busy(busy), .state_dbg(state_dbg)
  );

  operand2_shift_sequencer #(.STEP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .imm_mode(imm_mode), .imm8(imm8), .rot4(rot4), .operand(operand),
    .shift_type(shift_type), .shift_amt(shift_amt), .carry_in(carry_in),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
    .carry_out(carry_out1), .busy(busy1), .state_dbg(state_dbg1)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fields(input logic im, input logic [7:0] i8, input logic [3:0] r4,
                            input logic [31:0] op, input logic [1:0] st,
                            input logic [7:0] sa, input logic ci);
    imm_mode = im; imm8 = i8; rot4 = r4; operand = op;
    shift_type = st; shift_amt = sa; carry_in = ci;
  endtask

  task automatic send(input logic im, input logic [7:0] i8, input logic [3:0] r4,
                      input logic [31:0] op, input logic [1:0] st, input logic [7:0] sa,
                      input logic ci, input logic [31:0] er, input logic ec,
                      input logic [7:0] el);
    int waited = 0;
    @(negedge clk);
    set_fields(im, i8, r4, op, st, sa, ci);
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      exp_q.push_back({el, ec, er});
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] op, input logic [1:0] st, input logic [7:0] sa,
                       input logic [31:0] er, input logic ec, input logic [7:0] el);
    int waited = 0;
    @(negedge clk);
    set_fields(1'b0, 8'h00, 4'h0, op, st, sa, 1'b0);
    in_valid1 = 1'b1;
    while (!in_ready1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      check("accept1_timeout", {31'b0, in_ready1}, 32'd1);
    end else begin
      exp1_q.push_back({el, ec, er});
      acc1_q.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0 || !in_ready || !in_ready1)
           && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) check("drain_timeout", 32'(exp_q.size() + exp1_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitors ----------------
  logic         seen = 1'b0;
  logic [W-1:0] cur;
  int           cur_acc;

  always @(negedge clk) begin
    if (!reset_n || !out_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", result, 32'hxxxxxxxx);
        end else begin
          cur     = exp_q.pop_front();
          cur_acc = acc_q.pop_front();
          seen    = 1'b1;
          check("result", result, cur[31:0]);
          check("carry", {31'b0, carry_out}, {31'b0, cur[32]});
          check("latency", 32'(cyc - cur_acc + 1), {24'b0, cur[40:33]});
        end
      end else begin
        check("hold_result", result, cur[31:0]);
        check("hold_carry", {31'b0, carry_out}, {31'b0, cur[32]});
        check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (out_ready) seen = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    int a;
    if (reset_n && out_valid1) begin
      if (exp1_q.size() == 0) begin
        check("unexpected_output1", result1, 32'hxxxxxxxx);
      end else begin
        e = exp1_q.pop_front();
        a = acc1_q.pop_front();
        check("step1_result", result1, e[31:0]);
        check("step1_carry", {31'b0, carry_out1}, {31'b0, e[32]});
        check("step1_latency", 32'(cyc - a + 1), {24'b0, e[40:33]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    reset_n = 1'b0;
    in_valid = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b1; out_ready1 = 1'b1;
    set_fields(1'b0, 8'h00, 4'h0, 32'h0, 2'b00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_carry", {31'b0, carry_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_in_ready1", {31'b0, in_ready1}, 32'd1);
    reset_n = 1'b1;

    // immediate form
    send(1'b1, 8'hFF, 4'd4, 32'h0, 2'b00, 8'd0, 1'b0, 32'hFF000000, 1'b1, 8'd3);
    send(1'b1, 8'h2A, 4'd0, 32'h0, 2'b00, 8'd0, 1'b1, 32'h0000002A, 1'b1, 8'd1);
    send(1'b1, 8'h81, 4'd1, 32'h0, 2'b00, 8'd0, 1'b1, 32'h40000020, 1'b0, 8'd2);
    // LSL
    send(1'b0, 8'h00, 4'd0, 32'h80000001, 2'b00, 8'd1,  1'b0, 32'h00000002, 1'b1, 8'd2);
    send(1'b0, 8'h00, 4'd0, 32'h80000001, 2'b00, 8'd32, 1'b0, 32'h00000000, 1'b1, 8'd1);
    send(1'b0, 8'h00, 4'd0, 32'h80000001, 2'b00, 8'd33, 1'b1, 32'h00000000, 1'b0, 8'd1);
    send(1'b0, 8'h00, 4'd0, 32'hF8000000, 2'b00, 8'd5,  1'b0, 32'h00000000, 1'b1, 8'd3);
    // LSR
    send(1'b0, 8'h00, 4'd0, 32'h80000001, 2'b01, 8'd32, 1'b0, 32'h00000000, 1'b1, 8'd1);
    send(1'b0, 8'h00, 4'd0, 32'h80000001, 2'b01, 8'd4,  1'b1, 32'h08000000, 1'b0, 8'd2);
    // ASR
    send(1'b0, 8'h00, 4'd0, 32'h80000000, 2'b10, 8'd31, 1'b1, 32'hFFFFFFFF, 1'b0, 8'd9);
    send(1'b0, 8'h00, 4'd0, 32'h80000000, 2'b10, 8'd40, 1'b0, 32'hFFFFFFFF, 1'b1, 8'd1);
    send(1'b0, 8'h00, 4'd0, 32'h40000000, 2'b10, 8'd3,  1'b1, 32'h08000000, 1'b0, 8'd2);
    // ROR
    send(1'b0, 8'h00, 4'd0, 32'h12345678, 2'b11, 8'd36, 1'b0, 32'h81234567, 1'b1, 8'd2);
    send(1'b0, 8'h00, 4'd0, 32'h12345678, 2'b11, 8'd64, 1'b1, 32'h12345678, 1'b0, 8'd1);
    send(1'b0, 8'h00, 4'd0, 32'h12345678, 2'b11, 8'd0,  1'b0, 32'h12345678, 1'b0, 8'd1);
    send(1'b0, 8'h00, 4'd0, 32'h12345678, 2'b11, 8'd5,  1'b0, 32'hC091A2B3, 1'b1, 8'd3);
    drain();

    // STEP=1 instance: ASR 31 takes one cycle per bit
    send1(32'h80000000, 2'b10, 8'd31, 32'hFFFFFFFF, 1'b0, 8'd32);
    drain();

    // backpressure: result held, new request ignored while DONE
    out_ready = 1'b0;
    send(1'b0, 8'h00, 4'd0, 32'hA5A5A5A5, 2'b01, 8'd8, 1'b0, 32'h00A5A5A5, 1'b1, 8'd3);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    set_fields(1'b1, 8'h11, 4'd0, 32'h0, 2'b00, 8'd0, 1'b1);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_busy", {31'b0, busy}, 32'd1);
      check("bp_state", 32'(state_dbg), 32'(DONE));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
    check("bp_out_valid_after", {31'b0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    drain();

    // asynchronous reset mid-SHIFT
    send(1'b0, 8'h00, 4'd0, 32'h80000000, 2'b10, 8'd31, 1'b0, 32'hFFFFFFFF, 1'b0, 8'd9);
    repeat (2) @(negedge clk);
    check("mid_state", 32'(state_dbg), 32'(SHIFT));
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_result", result, 32'h0);
    check("arst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

    send(1'b0, 8'h00, 4'd0, 32'h12345678, 2'b11, 8'd36, 1'b0, 32'h81234567, 1'b1, 8'd2);
    drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
